bus_txn_history: RTL and testbench
==================================

// Module: bus_txn_history
// PURPOSE
//  Snoops the internal register bus (valid/addr/data/rw) in the user clock domain.
//  Filters transactions by address window and direction and stores the last DEPTH in a circular history.
//  Presents one selected entry as {addr,data} plus rw for the 7-segment/LED debug display.
//  Successor to the single-entry last-transaction latch.
//  Adds depth, filtering, step-through browsing and an overflow indication.
// PARAMETERS
//  ADDR_WIDTH    16       bus address width
//  DATA_WIDTH    16       bus data width
//  DEPTH         8        history entries; power of 2, >=2
//  ADDR_LO       0        lowest captured address (inclusive)
//  ADDR_HI       'hFFFF   highest captured address (inclusive)
//  CAPTURE_MODE  0        0 = all transactions, 1 = reads only (rw=0), 2 = writes only (rw=1)
// PORTS
//  clk        in   1                      user clock
//  rst        in   1                      reset, asynchronous, active-high
//  bus_valid  in   1                      bus transaction strobe, one cycle per transaction
//  bus_addr   in   ADDR_WIDTH             transaction address
//  bus_data   in   DATA_WIDTH             transaction data
//  bus_rw     in   1                      1 = write, 0 = read
//  step       in   1                      single-cycle pulse: select next-older entry
//  latest     in   1                      single-cycle pulse: select newest entry
//  clear      in   1                      single-cycle pulse: flush history
//  freeze     in   1                      suspend capture; present only with BUS_MON_FREEZE_EN
//  disp_val   out  ADDR_WIDTH+DATA_WIDTH  {addr,data} of the selected entry
//  disp_rw    out  1                      rw of the selected entry
//  disp_sel   out  $clog2(DEPTH)          age of the selected entry; 0 = newest
//  entries    out  $clog2(DEPTH+1)        valid entry count, saturates at DEPTH
//  wrapped    out  1                      sticky: an entry has been overwritten
// BEHAVIOUR
//  - Reset, asynchronous: all outputs 0; wr_ptr = 0, sel = 0; memory contents are don't-care.
//  - Capture condition: bus_valid, ADDR_LO <= bus_addr <= ADDR_HI, CAPTURE_MODE matches, and clear low.
//  - On capture: write mem[wr_ptr]; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
//  - On capture: entries <= min(entries+1, DEPTH).
//  - On capture with entries == DEPTH: wrapped <= 1.
//  - clear: entries, wr_ptr, sel and wrapped <= 0. clear beats capture, step and latest in the same cycle.
//  - Selection update, in this order each cycle:
//    (a) latest: sel <= 0. latest beats step.
//    (b) step with entries > 0: sel <= sel+1, or 0 if sel+1 >= entries (pre-capture count).
//        step with entries == 0: ignored.
//    (c) capture with the post-(b) sel != 0: sel <= min(sel+1, DEPTH-1).
//        The view stays on the same transaction until that entry is overwritten.
//    With sel == 0 the display tracks the newest transaction live.
//  - Display outputs are registered from the post-edge state: mem[(wr_ptr-1-sel) mod DEPTH].
//    Latency: capture sampled at edge N, visible on disp_val at edge N+1.
//  - entries == 0: disp_val = 0, disp_rw = 0, disp_sel = 0.
//  - Back-to-back bus_valid on every cycle: each one is captured. No throughput limit.
// CONFIGURATION
//  - BUS_MON_FREEZE_EN defined: port freeze exists.
//    While freeze is 1, capture is suppressed; entries, wr_ptr and wrapped hold.
//    step, latest and clear still operate.
//  - BUS_MON_FREEZE_EN undefined: no freeze port; capture is never suppressed.
// STRUCTURE
//  - bus_mon_pkg holds:
//    - entry_t: packed struct {addr, data, rw}
//    - capture_mode_e: CAP_ALL = 0, CAP_READ = 1, CAP_WRITE = 2
//    - function in_window(addr, lo, hi)
//  - Sub-module bus_mon_history: DEPTH x entry_t circular buffer.
//    One synchronous write port and one asynchronous read port addressed by age.
//    It owns wr_ptr, entries and wrapped.
//  - Top level owns the filter, the selection logic and the display registers.
// TESTING
//  1. Reset, 3 writes to 0x0010/0x0011/0x0012 (data 0xA1..A3), mode 0
//     -> entries = 3, disp_val = 0x0012_00A3, disp_rw = 1.
//  2. Then step x2 -> disp_val = 0x0010_00A1, disp_sel = 2.
//     Step again -> disp_sel wraps to 0.
//  3. DEPTH = 8: 10 captures of data 0..9 -> entries = 8, wrapped = 1.
//     Step x7 shows data 2.
//  4. sel = 2 viewing data 0xB5, then a new capture arrives
//     -> sel = 3, disp_val unchanged. latest together with step -> sel = 0.
//  5. ADDR_LO = 0x20, ADDR_HI = 0x2F, mode 2: read 0x25, write 0x30, write 0x2F
//     -> only 0x2F captured, entries = 1.
//  6. Async rst mid-burst, clear together with bus_valid, and with BUS_MON_FREEZE_EN freeze = 1 during a capture
//     -> all outputs 0 / entries 0 / no capture and state held.

Source files
------------

// File: rtl/bus_mon_pkg.sv
// Shared types for the register-bus transaction history monitor.
// entry_t is sized for the 16-bit register bus; the top level converts
// explicitly when built with other bus widths.
package bus_mon_pkg;

   localparam int ENTRY_ADDR_W = 16;
   localparam int ENTRY_DATA_W = 16;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] addr;
      logic [ENTRY_DATA_W-1:0] data;
      logic                    rw;
   } entry_t;

   typedef enum logic [1:0] {
      CAP_ALL   = 2'd0,
      CAP_READ  = 2'd1,
      CAP_WRITE = 2'd2
   } capture_mode_e;

   function automatic logic in_window(input logic [ENTRY_ADDR_W-1:0] addr,
                                      input logic [ENTRY_ADDR_W-1:0] lo,
                                      input logic [ENTRY_ADDR_W-1:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/bus_txn_history_if.sv
// Register-bus snoop interface: one-cycle valid strobe with addr/data/rw.
interface bus_txn_history_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  valid;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;
   logic                  rw;

   modport master (output valid, addr, data, rw);
   modport slave  (input  valid, addr, data, rw);
endinterface

// File: rtl/bus_mon_history.sv
// Circular history of captured bus entries. Synchronous write at wr_ptr,
// asynchronous read addressed by age (0 = newest). Owns the write pointer,
// the saturating entry count and the sticky overwrite flag.
module bus_mon_history
   import bus_mon_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  entry_t                     wr_entry,
   input  logic [$clog2(DEPTH)-1:0]   rd_age,
   output entry_t                     rd_entry,
   output logic [$clog2(DEPTH+1)-1:0] entries,
   output logic                       wrapped
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;

   // Storage: contents are never reset, validity is tracked by entries.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_entry;
   end

   // Pointer, count and overwrite bookkeeping; the pointer wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         entries <= '0;
         wrapped <= 1'b0;
      end else if (clr) begin
         wr_ptr  <= '0;
         entries <= '0;
         wrapped <= 1'b0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (entries == CNT_W'(DEPTH)) wrapped <= 1'b1;
         else                          entries <= entries + 1'b1;
      end
   end

   assign rd_entry = mem[wr_ptr - PTR_W'(1) - rd_age];

endmodule

// File: rtl/bus_txn_history.sv
// Register-bus transaction history for the debug display.
// Filters snooped transactions by address window and direction, keeps the
// last DEPTH in bus_mon_history and presents one entry chosen by age.
// Optional feature: define BUS_MON_FREEZE_EN to add the freeze input,
// which suspends capture while browsing controls keep working.
module bus_txn_history
   import bus_mon_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 16,
   parameter int                    DATA_WIDTH   = 16,
   parameter int                    DEPTH        = 8,
   parameter logic [ADDR_WIDTH-1:0] ADDR_LO      = '0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_HI      = {ADDR_WIDTH{1'b1}},
   parameter int unsigned           CAPTURE_MODE = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   bus_txn_history_if.slave                 bus,
   input  logic                             step,
   input  logic                             latest,
   input  logic                             clear,
`ifdef BUS_MON_FREEZE_EN
   input  logic                             freeze,
`endif
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] disp_val,
   output logic                             disp_rw,
   output logic [$clog2(DEPTH)-1:0]         disp_sel,
   output logic [$clog2(DEPTH+1)-1:0]       entries,
   output logic                             wrapped
);
   localparam int            SEL_W = $clog2(DEPTH);
   localparam int            CNT_W = $clog2(DEPTH+1);
   localparam capture_mode_e MODE  = capture_mode_e'(CAPTURE_MODE[1:0]);

   logic             hold;
   logic             mode_ok;
   logic             cap;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] sel_nxt;
   entry_t           wr_entry;
   entry_t           rd_entry;

`ifdef BUS_MON_FREEZE_EN
   assign hold = freeze;
`else
   assign hold = 1'b0;
`endif

   // Direction filter and capture qualification; clear always wins.
   always_comb begin
      mode_ok = 1'b1;
      case (MODE)
         CAP_READ:  mode_ok = ~bus.rw;
         CAP_WRITE: mode_ok = bus.rw;
         default:   mode_ok = 1'b1;
      endcase
      cap = bus.valid && mode_ok && !clear && !hold &&
            in_window(ENTRY_ADDR_W'(bus.addr), ENTRY_ADDR_W'(ADDR_LO), ENTRY_ADDR_W'(ADDR_HI));
      wr_entry      = '0;
      wr_entry.addr = ENTRY_ADDR_W'(bus.addr);
      wr_entry.data = ENTRY_DATA_W'(bus.data);
      wr_entry.rw   = bus.rw;
   end

   // Next selection: latest, then step (wraps on the pre-capture count),
   // then age the view so it stays on the same transaction after a capture.
   always_comb begin
      sel_nxt = sel;
      if (latest) begin
         sel_nxt = '0;
      end else if (step && (entries != '0)) begin
         if ((CNT_W'(sel) + CNT_W'(1)) >= entries) sel_nxt = '0;
         else                                      sel_nxt = sel + 1'b1;
      end
      if (cap && (sel_nxt != '0) && (sel_nxt != SEL_W'(DEPTH-1)))
         sel_nxt = sel_nxt + 1'b1;
   end

   // Selection register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        sel <= '0;
      else if (clear) sel <= '0;
      else            sel <= sel_nxt;
   end

   bus_mon_history #(.DEPTH(DEPTH)) u_history (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .wr_en    (cap),
      .wr_entry (wr_entry),
      .rd_age   (sel),
      .rd_entry (rd_entry),
      .entries  (entries),
      .wrapped  (wrapped)
   );

   // Display registers, loaded from the state left by the previous edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_val <= '0;
         disp_rw  <= 1'b0;
         disp_sel <= '0;
      end else if (entries == '0) begin
         disp_val <= '0;
         disp_rw  <= 1'b0;
         disp_sel <= '0;
      end else begin
         disp_val <= {ADDR_WIDTH'(rd_entry.addr), DATA_WIDTH'(rd_entry.data)};
         disp_rw  <= rd_entry.rw;
         disp_sel <= sel;
      end
   end

endmodule

// File: tb/tb_bus_txn_history.sv
// Bench for bus_txn_history: two instances (full window / all directions,
// and window 0x20..0x2F / writes only) share one snooped bus and are compared
// every cycle against a queue-based history model, plus directed scenarios.
module tb_bus_txn_history;
   import bus_mon_pkg::*;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int SW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH+1);
`ifdef BUS_MON_FREEZE_EN
   localparam bit FRZ_EN = 1'b1;
`else
   localparam bit FRZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic step, latest, clear, freeze;

   logic [AW+DW-1:0] dv   [2];
   logic             drw  [2];
   logic [SW-1:0]    dsel [2];
   logic [CW-1:0]    dent [2];
   logic             dwr  [2];

   int n_chk  = 0;
   int n_fail = 0;

   // Model state, per instance: history newest-first as {rw, addr, data}.
   logic [AW+DW:0] hist [2][$];
   int             msel [2];
   bit             mwrap[2];
   int             m_lo [2] = '{0, 'h20};
   int             m_hi [2] = '{'hFFFF, 'h2F};
   int             m_mode[2] = '{0, 2};

   always #5 clk = ~clk;

   bus_txn_history_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bus_txn_history #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut0 (
      .clk(clk), .rst(rst), .bus(bus), .step(step), .latest(latest), .clear(clear),
`ifdef BUS_MON_FREEZE_EN
      .freeze(freeze),
`endif
      .disp_val(dv[0]), .disp_rw(drw[0]), .disp_sel(dsel[0]),
      .entries(dent[0]), .wrapped(dwr[0]));

   bus_txn_history #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                     .ADDR_LO(16'h0020), .ADDR_HI(16'h002F), .CAPTURE_MODE(2)) dut1 (
      .clk(clk), .rst(rst), .bus(bus), .step(step), .latest(latest), .clear(clear),
`ifdef BUS_MON_FREEZE_EN
      .freeze(freeze),
`endif
      .disp_val(dv[1]), .disp_rw(drw[1]), .disp_sel(dsel[1]),
      .entries(dent[1]), .wrapped(dwr[1]));

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         hist[i].delete();
         msel[i]  = 0;
         mwrap[i] = 1'b0;
      end
   endtask

   // Apply one clock edge's worth of the behavioural rules to instance i.
   task automatic model_update(input int i);
      int n;
      bit cap;
      n = hist[i].size();
      if (clear) begin
         hist[i].delete();
         msel[i]  = 0;
         mwrap[i] = 1'b0;
         return;
      end
      cap = bus.valid && (int'(bus.addr) >= m_lo[i]) && (int'(bus.addr) <= m_hi[i]) &&
            (m_mode[i] == 0 || (m_mode[i] == 1 && !bus.rw) || (m_mode[i] == 2 && bus.rw)) &&
            !(FRZ_EN && freeze);
      if (latest)                msel[i] = 0;
      else if (step && n > 0)    msel[i] = (msel[i] + 1 >= n) ? 0 : msel[i] + 1;
      if (cap && msel[i] != 0)   msel[i] = (msel[i] + 1 > DEPTH - 1) ? DEPTH - 1 : msel[i] + 1;
      if (cap) begin
         hist[i].push_front({bus.rw, bus.addr, bus.data});
         if (hist[i].size() > DEPTH) begin
            void'(hist[i].pop_back());
            mwrap[i] = 1'b1;
         end
      end
   endtask

   // One clock: expected display comes from the model state before the edge.
   task automatic tick();
      logic [AW+DW-1:0] ev [2];
      logic             er [2];
      int               es [2];
      logic [AW+DW:0]   e;
      for (int i = 0; i < 2; i++) begin
         if (hist[i].size() == 0) begin
            ev[i] = '0; er[i] = 1'b0; es[i] = 0;
         end else begin
            e = hist[i][msel[i]];
            ev[i] = e[AW+DW-1:0]; er[i] = e[AW+DW]; es[i] = msel[i];
         end
         model_update(i);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("d%0d_val", i), 64'(dv[i]), 64'(ev[i]));
         check_eq($sformatf("d%0d_rw", i), 64'(drw[i]), 64'(er[i]));
         check_eq($sformatf("d%0d_sel", i), 64'(dsel[i]), 64'(es[i]));
         check_eq($sformatf("d%0d_entries", i), 64'(dent[i]), 64'(hist[i].size()));
         check_eq($sformatf("d%0d_wrapped", i), 64'(dwr[i]), 64'(mwrap[i]));
      end
   endtask

   task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit w, input bit st = 0, input bit lt = 0, input bit cl = 0);
      bus.valid = v; bus.addr = a; bus.data = d; bus.rw = w;
      step = st; latest = lt; clear = cl;
      tick();
      bus.valid = 1'b0; step = 1'b0; latest = 1'b0; clear = 1'b0;
   endtask

   task automatic idle();
      cyc(0, '0, '0, 0);
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s_d%0d_val", tag, i), 64'(dv[i]), 64'd0);
         check_eq($sformatf("%s_d%0d_sel", tag, i), 64'(dsel[i]), 64'd0);
         check_eq($sformatf("%s_d%0d_ent", tag, i), 64'(dent[i]), 64'd0);
         check_eq($sformatf("%s_d%0d_wrap", tag, i), 64'(dwr[i]), 64'd0);
         check_eq($sformatf("%s_d%0d_rw", tag, i), 64'(drw[i]), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int held;
      rst = 1'b1; step = 0; latest = 0; clear = 0; freeze = 0;
      bus.valid = 0; bus.addr = '0; bus.data = '0; bus.rw = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // 1: three writes, newest shown live
      cyc(1, 16'h0010, 16'h00A1, 1);
      cyc(1, 16'h0011, 16'h00A2, 1);
      cyc(1, 16'h0012, 16'h00A3, 1);
      idle();
      check_eq("t1_entries", 64'(dent[0]), 64'd3);
      check_eq("t1_disp", 64'(dv[0]), 64'h0012_00A3);
      check_eq("t1_rw", 64'(drw[0]), 64'd1);

      // 2: step back twice, then wrap to newest
      cyc(0, '0, '0, 0, 1);
      cyc(0, '0, '0, 0, 1);
      idle();
      check_eq("t2_disp", 64'(dv[0]), 64'h0010_00A1);
      check_eq("t2_sel", 64'(dsel[0]), 64'd2);
      cyc(0, '0, '0, 0, 1);
      idle();
      check_eq("t2_wrap_sel", 64'(dsel[0]), 64'd0);

      // 3: overflow the history
      cyc(0, '0, '0, 0, 0, 0, 1);
      for (int k = 0; k < 10; k++) cyc(1, 16'(16'h0100 + k), 16'(k), k[0]);
      idle();
      check_eq("t3_entries", 64'(dent[0]), 64'd8);
      check_eq("t3_wrapped", 64'(dwr[0]), 64'd1);
      for (int k = 0; k < 7; k++) cyc(0, '0, '0, 0, 1);
      idle();
      check_eq("t3_oldest", 64'(dv[0][DW-1:0]), 64'd2);

      // 4: view stays on its transaction across a capture
      cyc(0, '0, '0, 0, 0, 0, 1);
      for (int k = 3; k <= 7; k++) cyc(1, 16'h0040, 16'(16'hB0 + k), 1);
      cyc(0, '0, '0, 0, 1);
      cyc(0, '0, '0, 0, 1);
      idle();
      check_eq("t4_before", 64'(dv[0][DW-1:0]), 64'hB5);
      cyc(1, 16'h0040, 16'h00B8, 1);
      idle();
      check_eq("t4_sel_aged", 64'(dsel[0]), 64'd3);
      check_eq("t4_same_view", 64'(dv[0][DW-1:0]), 64'hB5);
      cyc(0, '0, '0, 0, 1, 1);
      idle();
      check_eq("t4_latest_sel", 64'(dsel[0]), 64'd0);
      check_eq("t4_latest_val", 64'(dv[0][DW-1:0]), 64'hB8);

      // 5: window + writes-only filter
      cyc(0, '0, '0, 0, 0, 0, 1);
      cyc(1, 16'h0025, 16'h1111, 0);
      cyc(1, 16'h0030, 16'h2222, 1);
      cyc(1, 16'h002F, 16'h3333, 1);
      idle();
      check_eq("t5_entries", 64'(dent[1]), 64'd1);
      check_eq("t5_disp", 64'(dv[1]), 64'h002F_3333);

      // 6: async reset mid-burst, clear against capture, freeze
      for (int k = 0; k < 4; k++) cyc(1, 16'h0028, 16'(16'hC0 + k), 1);
      bus.valid = 1'b1; bus.addr = 16'h0029; bus.rw = 1'b1;
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_zero("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.valid = 1'b0;
      cyc(1, 16'h0021, 16'h0D01, 1);
      cyc(1, 16'h0022, 16'h0D02, 1, 0, 0, 1);
      idle();
      check_eq("t6_clear_cap", 64'(dent[0]), 64'd0);
      if (FRZ_EN) begin
         cyc(1, 16'h0023, 16'h0E01, 1);
         held = hist[0].size();
         freeze = 1'b1;
         cyc(1, 16'h0024, 16'h0E02, 1);
         freeze = 1'b0;
         check_eq("t6_freeze_hold", 64'(dent[0]), 64'(held));
      end

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         freeze = FRZ_EN && ($urandom_range(0, 9) == 0);
         cyc($urandom_range(0, 1), 16'($urandom_range(16'h18, 16'h38)), 16'($urandom),
             $urandom_range(0, 1), $urandom_range(0, 4) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
      end
      freeze = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
